// File: rtl/repacker_n_to_m.sv
// Width down-converter: IN_BYTES-wide words pass through a DEPTH-entry FIFO and
// leave as OUT_BYTES-wide beats with per-byte strobes and packet framing.
module repacker_n_to_m #(
    parameter int IN_BYTES  = 4,
    parameter int OUT_BYTES = 1,
    parameter int DEPTH     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       src_valid,
    output logic                       src_ready,
    input  logic [IN_BYTES*8-1:0]      src_data,
    input  logic [IN_BYTES-1:0]        src_strb,
    input  logic                       src_sop,
    input  logic                       src_eop,
    output logic                       sink_valid,
    input  logic                       sink_ready,
    output logic [OUT_BYTES*8-1:0]     sink_data,
    output logic [OUT_BYTES-1:0]       sink_strb,
    output logic                       sink_sop,
    output logic                       sink_eop,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       err_strb
);

    localparam int G  = IN_BYTES / OUT_BYTES;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int IW = IN_BYTES * 8;
    localparam int OW = OUT_BYTES * 8;
    localparam int EW = 2 + IN_BYTES + IW;

    // A hole is a cleared strobe bit sitting below some set strobe bit.
    function automatic logic strb_hole(input logic [IN_BYTES-1:0] s);
        logic seen;
        logic hole;
        seen = 1'b0;
        hole = 1'b0;
        for (int i = IN_BYTES - 1; i >= 0; i--) begin
            if (seen && !s[i]) hole = 1'b1;
            if (s[i]) seen = 1'b1;
        end
        return hole;
    endfunction

    // Beats needed for a word: groups up to the highest valid byte, at least one.
    function automatic int beat_count(input logic [IN_BYTES-1:0] s);
        int nb;
        int ng;
        nb = 0;
        for (int i = 0; i < IN_BYTES; i++) begin
            if (s[i]) nb = i + 1;
        end
        ng = (nb + OUT_BYTES - 1) / OUT_BYTES;
        return (ng == 0) ? 1 : ng;
    endfunction

    logic [EW-1:0]        mem_r [DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [LW-1:0]        level_r;
    logic [GW-1:0]        g_r;
    logic                 err_r;

    logic [EW-1:0]        head_s;
    logic                 head_sop_s;
    logic                 head_eop_s;
    logic [IN_BYTES-1:0]  head_strb_s;
    logic [IW-1:0]        head_data_s;
    logic [GW:0]          ng_s;
    logic                 last_s;
    logic                 push_s;
    logic                 store_s;
    logic                 beat_s;
    logic                 pop_s;

    assign head_s = mem_r[rd_ptr_r];
    assign {head_sop_s, head_eop_s, head_strb_s, head_data_s} = head_s;
    assign ng_s   = (GW + 1)'(beat_count(head_strb_s));
    assign last_s = ({1'b0, g_r} == (ng_s - (GW + 1)'(1)));

    assign src_ready = !rst && (level_r != LW'(DEPTH));
    assign push_s    = src_valid && src_ready;
    // Empty non-final words carry nothing and are swallowed on accept.
    assign store_s   = push_s && ((src_strb != {IN_BYTES{1'b0}}) || src_eop);
    assign beat_s    = sink_valid && sink_ready;
    assign pop_s     = beat_s && last_s;

    assign sink_valid = (level_r != LW'(0));
    assign sink_data  = head_data_s[g_r * OW +: OW];
    assign sink_strb  = head_strb_s[g_r * OUT_BYTES +: OUT_BYTES];
    assign sink_sop   = sink_valid && head_sop_s && (g_r == GW'(0));
    assign sink_eop   = sink_valid && head_eop_s && last_s;
    assign fifo_level = level_r;
    assign err_strb   = err_r;

    // FIFO storage: no reset needed, contents are qualified by level_r.
    always_ff @(posedge clk) begin
        if (!rst && store_s) begin
            mem_r[wr_ptr_r] <= {src_sop, src_eop, src_strb, src_data};
        end
    end

    // Pointers, occupancy, group counter and sticky strobe-hole flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            level_r  <= LW'(0);
            g_r      <= GW'(0);
            err_r    <= 1'b0;
        end else begin
            if (store_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({store_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
            if (beat_s) g_r <= last_s ? GW'(0) : g_r + GW'(1);
            if (push_s && strb_hole(src_strb)) err_r <= 1'b1;
        end
    end

endmodule
